// File: rtl/bcd_counter_scan.sv
// Multi-digit BCD counter with selectable tick rate, up/down, pause and load,
// driving a time-multiplexed active-low-anode 7-segment display.
module bcd_counter_scan #(
    parameter int unsigned DIGITS   = 2,
    parameter int unsigned MODULUS  = 60,
    parameter int unsigned DIV0     = 50_000_000,
    parameter int unsigned DIV1     = 25_000_000,
    parameter int unsigned DIV2     = 12_500_000,
    parameter int unsigned DIV3     = 5_000_000,
    parameter int unsigned SCAN_DIV = 50_000
) (
    input  logic                  CLK,
    input  logic                  rst_n,
    input  logic [1:0]            contral,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int unsigned CW   = 4 * DIGITS;
    localparam int unsigned M01  = (DIV0 > DIV1) ? DIV0 : DIV1;
    localparam int unsigned M23  = (DIV2 > DIV3) ? DIV2 : DIV3;
    localparam int unsigned DMAX = (M01 > M23) ? M01 : M23;
    localparam int unsigned PW   = $clog2(DMAX + 1);
    localparam int unsigned SW   = $clog2(SCAN_DIV + 1);
    localparam int unsigned IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0]     D0M1     = PW'(DIV0 - 1);
    localparam logic [PW-1:0]     D1M1     = PW'(DIV1 - 1);
    localparam logic [PW-1:0]     D2M1     = PW'(DIV2 - 1);
    localparam logic [PW-1:0]     D3M1     = PW'(DIV3 - 1);
    localparam logic [SW-1:0]     SCAN_M1  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]     LAST_IDX = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_RST   = ~DIGITS'(1);

    function automatic logic [CW-1:0] to_bcd(input int unsigned v);
        logic [CW-1:0] r;
        int unsigned   x;
        r = '0;
        x = v;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    localparam logic [CW-1:0] MAX_BCD = to_bcd(MODULUS - 1);

    logic [1:0]        ctl_q;
    logic [PW-1:0]     presc_q, presc_d;
    logic [CW-1:0]     count_q, count_d;
    logic              wrap_q, wrap_d;
    logic [SW-1:0]     scan_q, scan_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;

    logic [PW-1:0] div_m1;
    logic          chg, tick;
    logic [CW-1:0] inc, dec;
    logic          cy, bw, load_ok;
    logic [3:0]    dig;

    always_comb begin
        case (ctl_q)
            2'b00:   div_m1 = D0M1;
            2'b01:   div_m1 = D1M1;
            2'b10:   div_m1 = D2M1;
            default: div_m1 = D3M1;
        endcase
    end

    // A pending rate change suppresses the tick and restarts the prescaler.
    assign chg  = (contral != ctl_q);
    assign tick = !chg && (presc_q >= div_m1);

    always_comb begin
        presc_d = presc_q;
        if (chg || load)
            presc_d = '0;
        else if (en)
            presc_d = (presc_q >= div_m1) ? '0 : presc_q + PW'(1);
    end

    always_comb begin
        inc = count_q;
        dec = count_q;
        cy  = 1'b1;
        bw  = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (cy) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    inc[4*i +: 4] = 4'd0;
                end else begin
                    inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    cy = 1'b0;
                end
            end
            if (bw) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    dec[4*i +: 4] = 4'd9;
                end else begin
                    dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    bw = 1'b0;
                end
            end
        end
    end

    // Valid BCD compares like binary, so the range check is a plain vector compare.
    always_comb begin
        load_ok = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9)
                load_ok = 1'b0;
        end
        if (load_val > MAX_BCD)
            load_ok = 1'b0;
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = load_ok ? load_val : '0;
        end else if (tick && en) begin
            if (up) begin
                if (count_q == MAX_BCD) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = inc;
                end
            end else begin
                if (count_q == '0) begin
                    count_d = MAX_BCD;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = dec;
                end
            end
        end
    end

    always_comb begin
        scan_d = scan_q + SW'(1);
        idx_d  = idx_q;
        if (scan_q >= SCAN_M1) begin
            scan_d = '0;
            idx_d  = (idx_q >= LAST_IDX) ? '0 : idx_q + IW'(1);
        end
        dig  = 4'd0;
        an_d = '1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (IW'(i) == idx_d) begin
                dig     = count_q[4*i +: 4];
                an_d[i] = 1'b0;
            end
        end
        seg_d = seg7(dig);
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            ctl_q   <= 2'b00;
            presc_q <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
            scan_q  <= '0;
            idx_q   <= '0;
            an_q    <= AN_RST;
            seg_q   <= 7'b0111111;
        end else begin
            ctl_q   <= contral;
            presc_q <= presc_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign seg   = seg_q;
    assign an    = an_q;

endmodule

// File: tb/tb_bcd_counter_scan.sv
// Directed bench for bcd_counter_scan with small dividers; every expected value
// is hand-derived from the edge count since the last reset/load/rate change.
module tb_bcd_counter_scan;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic [1:0] contral;
    logic       en, up, load;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       wrap;
    logic [6:0] seg;
    logic [1:0] an;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [6:0] SEG0 = 7'b0111111;
    localparam logic [6:0] SEG5 = 7'b1101101;
    localparam logic [6:0] SEG7 = 7'b0000111;

    bcd_counter_scan #(
        .DIGITS   (2),
        .MODULUS  (60),
        .DIV0     (4),
        .DIV1     (2),
        .DIV2     (3),
        .DIV3     (1),
        .SCAN_DIV (2)
    ) dut (
        .CLK      (CLK),
        .rst_n    (rst_n),
        .contral  (contral),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .wrap     (wrap),
        .seg      (seg),
        .an       (an)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_count"}, count, 8'h00);
        chk({tag, "_wrap"},  wrap,  1'b0);
        chk({tag, "_an"},    an,    2'b10);
        chk({tag, "_seg"},   seg,   SEG0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        contral  = 2'b00;
        en       = 1'b0;
        up       = 1'b1;
        load     = 1'b0;
        load_val = 8'h00;

        // Power-on reset state
        step(3);
        chk_reset("por");

        // Load 37, then reset asynchronously mid-cycle
        rst_n    = 1'b1;
        load     = 1'b1;
        load_val = 8'h37;
        step(1);
        chk("ld37", count, 8'h37);
        load = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset("async_rst");

        // Count up at DIV0=4 from 0
        @(posedge CLK);
        #1;
        rst_n   = 1'b1;
        contral = 2'b00;
        en      = 1'b1;
        up      = 1'b1;
        step(3);
        chk("up_pre1", count, 8'h00);
        step(1);
        chk("up_1", count, 8'h01);
        step(32);
        chk("up_09", count, 8'h09);
        step(4);
        chk("up_10", count, 8'h10);
        step(196);
        chk("up_59", count, 8'h59);
        chk("up_59_wrap", wrap, 1'b0);
        step(3);
        chk("up_59_hold", count, 8'h59);
        step(1);
        chk("up_wrap_cnt", count, 8'h00);
        chk("up_wrap_pulse", wrap, 1'b1);
        step(1);
        chk("up_wrap_end", wrap, 1'b0);
        chk("up_after_wrap", count, 8'h00);

        // Count down at DIV3=1: wrap 00 -> 59
        contral = 2'b11;
        en      = 1'b0;
        step(1);
        chk("dn_setup", count, 8'h00);
        en = 1'b1;
        up = 1'b0;
        step(1);
        chk("dn_wrap_cnt", count, 8'h59);
        chk("dn_wrap_pulse", wrap, 1'b1);
        step(1);
        chk("dn_58", count, 8'h58);
        chk("dn_58_wrap", wrap, 1'b0);
        step(1);
        chk("dn_57", count, 8'h57);

        // Load priority over a tick, and invalid load values
        up       = 1'b1;
        load     = 1'b1;
        load_val = 8'h42;
        step(1);
        chk("ld42", count, 8'h42);
        chk("ld42_wrap", wrap, 1'b0);
        load = 1'b0;
        step(1);
        chk("ld42_inc", count, 8'h43);
        load     = 1'b1;
        load_val = 8'h7A;
        step(1);
        chk("ld7A", count, 8'h00);
        load_val = 8'h59;
        step(1);
        chk("ld59", count, 8'h59);
        load_val = 8'h65;
        step(1);
        chk("ld65", count, 8'h00);
        load_val = 8'h58;
        step(1);
        chk("ld58", count, 8'h58);
        load_val = 8'h60;
        step(1);
        chk("ld60", count, 8'h00);
        load_val = 8'h50;
        up       = 1'b0;
        step(1);
        chk("ld50", count, 8'h50);
        load = 1'b0;
        step(1);
        chk("dn_borrow_49", count, 8'h49);

        // Pause keeps prescaler phase
        up       = 1'b1;
        contral  = 2'b00;
        load     = 1'b1;
        load_val = 8'h13;
        step(1);
        chk("ld13", count, 8'h13);
        load = 1'b0;
        step(2);
        chk("pause_pre", count, 8'h13);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("pause_cnt", count, 8'h13);
            chk("pause_wrap", wrap, 1'b0);
        end
        en = 1'b1;
        step(1);
        chk("resume_1", count, 8'h13);
        step(1);
        chk("resume_tick", count, 8'h14);

        // Rate change clears the prescaler and suppresses the pending tick
        step(3);
        chk("rate_pre", count, 8'h14);
        contral = 2'b01;
        step(1);
        chk("rate_chg_edge", count, 8'h14);
        step(1);
        chk("rate_chg_1", count, 8'h14);
        step(1);
        chk("rate_chg_tick", count, 8'h15);

        // Display scan with count 57, fresh reset for known scan phase
        #2 rst_n = 1'b0;
        @(posedge CLK);
        #1;
        rst_n    = 1'b1;
        en       = 1'b0;
        load     = 1'b1;
        load_val = 8'h57;
        step(1);
        load = 1'b0;
        chk("scan_ld57", count, 8'h57);
        chk("scan_an_e1", an, 2'b10);
        chk("scan_seg_e1", seg, SEG0);
        for (int k = 2; k <= 9; k++) begin
            step(1);
            if (((k / 2) % 2) == 1) begin
                chk("scan_an_d1", an, 2'b01);
                chk("scan_seg_d1", seg, SEG5);
            end else begin
                chk("scan_an_d0", an, 2'b10);
                chk("scan_seg_d0", seg, SEG7);
            end
        end
        chk("scan_hold", count, 8'h57);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
